// File: rtl/board_ram_arbiter_pkg.sv
// board_ram_arbiter_pkg
//   Shared constants and types for the board-cell RAM arbiter.
//   ADDR_W/DATA_W : cell address and word widths
//   CELLS         : number of valid cells (20x20 board), addresses 0..CELLS-1
//   CLEAR_VAL     : word written to every cell by the clear sequencer
//   STARVE_MAX    : consecutive denied game cycles before game is forced through
package board_ram_arbiter_pkg;

  localparam int ADDR_W     = 9;
  localparam int DATA_W     = 16;
  localparam int CELLS      = 400;
  localparam int STARVE_MAX = 8;
  localparam int STARVE_W   = $clog2(STARVE_MAX + 1);

  // Return-pipeline lane indices.
  localparam int PORTS   = 2;
  localparam int PORT_VID = 0;
  localparam int PORT_GM  = 1;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] cell_t;

  localparam cell_t CLEAR_VAL = 16'h0;
  localparam addr_t LAST_CELL = addr_t'(CELLS - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    ARB   = 1'b1
  } arb_state_t;

  // True for addresses that map onto a real board cell.
  function automatic logic in_range(input addr_t a);
    return a <= LAST_CELL;
  endfunction

endpackage

// File: rtl/board_ram_arbiter_cell_clear_seq.sv
// board_ram_arbiter_cell_clear_seq
//   Address counter for the board clear. Walks 0..CELLS-1, one cell per
//   advance, then raises its done flag until the next start.
//   clk, reset_n : clock, asynchronous active-low reset
//   start        : restart the walk at address 0
//   advance      : the current address was written this cycle
//   addr         : cell address to write
//   busy         : walk in progress (done flag clear)
//   last         : addr is the final cell
module board_ram_arbiter_cell_clear_seq
  import board_ram_arbiter_pkg::*;
(
  input  logic  clk,
  input  logic  reset_n,
  input  logic  start,
  input  logic  advance,
  output addr_t addr,
  output logic  busy,
  output logic  last
);

  addr_t addr_reg;
  logic  done_reg;

  // A reset leaves the walk armed at address 0, so the board is cleared
  // without anyone having to ask.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_reg <= '0;
      done_reg <= 1'b0;
    end else if (start) begin
      addr_reg <= '0;
      done_reg <= 1'b0;
    end else if (advance && !done_reg) begin
      if (addr_reg == LAST_CELL) begin
        addr_reg <= '0;
        done_reg <= 1'b1;
      end else begin
        addr_reg <= addr_reg + addr_t'(1);
      end
    end
  end

  assign addr = addr_reg;
  assign busy = !done_reg;
  assign last = (addr_reg == LAST_CELL);

endmodule

// File: rtl/board_ram_arbiter.sv
// board_ram_arbiter
//   Shares one single-port synchronous board RAM between the video painter
//   and game logic, and clears the board after reset or on command.
//   clk, reset_n            : pixel clock, asynchronous active-low reset
//   clear_start/clear_busy  : clear command pulse / clear in progress
//   vid_req/addr/gnt        : video read request, address, same-cycle grant
//   vid_rvalid/rdata        : video read return (2 cycles after grant)
//   gm_req/we/addr/wdata    : game request (read or write), same-cycle grant gm_gnt
//   gm_rvalid/rdata         : game read return (reads only)
//   ram_addr/we/wdata/rdata : board RAM port; rdata valid 1 cycle after address
module board_ram_arbiter
  import board_ram_arbiter_pkg::*;
(
  input  logic  clk,
  input  logic  reset_n,
  input  logic  clear_start,
  output logic  clear_busy,
  input  logic  vid_req,
  input  addr_t vid_addr,
  output logic  vid_gnt,
  output logic  vid_rvalid,
  output cell_t vid_rdata,
  input  logic  gm_req,
  input  logic  gm_we,
  input  addr_t gm_addr,
  input  cell_t gm_wdata,
  output logic  gm_gnt,
  output logic  gm_rvalid,
  output cell_t gm_rdata,
  output addr_t ram_addr,
  output logic  ram_we,
  output cell_t ram_wdata,
  input  cell_t ram_rdata
);

  arb_state_t          state_reg, state_next;
  logic                run_reg;
  logic [STARVE_W-1:0] starve_reg, starve_next;
  logic                game_first;

  addr_t clr_addr;
  logic  clr_busy, clr_last, clr_start, clr_advance;

  // Per-lane return pipeline: stage 1 tags the RAM cycle, stage 2 holds data.
  logic  rd_issue    [PORTS];
  logic  rd_zero     [PORTS];
  logic  p1_valid_reg[PORTS];
  logic  p1_zero_reg [PORTS];
  logic  rvalid_reg  [PORTS];
  cell_t rdata_reg   [PORTS];

  board_ram_arbiter_cell_clear_seq u_clear_seq (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (clr_start),
    .advance (clr_advance),
    .addr    (clr_addr),
    .busy    (clr_busy),
    .last    (clr_last)
  );

  // run_reg is low while reset is held and for the first edge after release,
  // which keeps every output at 0 during reset and starts the clear from a
  // clean edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= CLEAR;
      run_reg    <= 1'b0;
      starve_reg <= '0;
    end else begin
      state_reg  <= state_next;
      run_reg    <= 1'b1;
      starve_reg <= starve_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    starve_next = starve_reg;
    clr_start   = 1'b0;
    clr_advance = 1'b0;
    vid_gnt     = 1'b0;
    gm_gnt      = 1'b0;
    ram_addr    = '0;
    ram_we      = 1'b0;
    ram_wdata   = '0;
    game_first  = (starve_reg == STARVE_W'(STARVE_MAX));

    if (run_reg) begin
      case (state_reg)
        CLEAR: begin
          clr_advance = 1'b1;
          ram_addr    = clr_addr;
          ram_we      = 1'b1;
          ram_wdata   = CLEAR_VAL;
          if (clr_last) begin
            state_next = ARB;
          end
          // No grants here, so a pending game request is neither served
          // nor counted as denied; a withdrawn one still clears the count.
          if (!gm_req) begin
            starve_next = '0;
          end
        end

        ARB: begin
          // Grants in this cycle still complete; the clear starts next cycle.
          if (clear_start) begin
            clr_start  = 1'b1;
            state_next = CLEAR;
          end

          if (gm_req && (!vid_req || game_first)) begin
            gm_gnt    = 1'b1;
            ram_addr  = gm_addr;
            ram_we    = gm_we && in_range(gm_addr);
            ram_wdata = gm_wdata;
          end else if (vid_req) begin
            vid_gnt   = 1'b1;
            ram_addr  = vid_addr;
          end

          if (!gm_req || gm_gnt) begin
            starve_next = '0;
          end else if (!game_first) begin
            starve_next = starve_reg + STARVE_W'(1);
          end
        end

        default: begin
          state_next = CLEAR;
        end
      endcase
    end
  end

  always_comb begin
    rd_issue[PORT_VID] = vid_gnt;
    rd_zero[PORT_VID]  = !in_range(vid_addr);
    rd_issue[PORT_GM]  = gm_gnt && !gm_we;
    rd_zero[PORT_GM]   = !in_range(gm_addr);
  end

  // Grant in T -> RAM data in T+1 -> registered result and rvalid in T+2.
  // Out-of-range reads still flow through the pipe but return 0.
  generate
    for (genvar gi = 0; gi < PORTS; gi++) begin : g_ret
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          p1_valid_reg[gi] <= 1'b0;
          p1_zero_reg[gi]  <= 1'b0;
          rvalid_reg[gi]   <= 1'b0;
          rdata_reg[gi]    <= '0;
        end else begin
          p1_valid_reg[gi] <= rd_issue[gi];
          p1_zero_reg[gi]  <= rd_zero[gi];
          rvalid_reg[gi]   <= p1_valid_reg[gi];
          if (p1_valid_reg[gi]) begin
            rdata_reg[gi] <= p1_zero_reg[gi] ? '0 : ram_rdata;
          end
        end
      end
    end
  endgenerate

  assign clear_busy = run_reg && clr_busy;
  assign vid_rvalid = rvalid_reg[PORT_VID];
  assign vid_rdata  = rdata_reg[PORT_VID];
  assign gm_rvalid  = rvalid_reg[PORT_GM];
  assign gm_rdata   = rdata_reg[PORT_GM];

endmodule

// File: tb/tb_board_ram_arbiter.sv
// tb_board_ram_arbiter
//   Directed bench for board_ram_arbiter with a registered-read RAM model.
//   A vector table covers single transactions; hand sequences cover the
//   reset clear, starvation, clear_start mid-stream and reset mid-clear.
module tb_board_ram_arbiter;

  logic        clk;
  logic        reset_n;
  logic        clear_start;
  logic        clear_busy;
  logic        vid_req;
  logic [8:0]  vid_addr;
  logic        vid_gnt;
  logic        vid_rvalid;
  logic [15:0] vid_rdata;
  logic        gm_req;
  logic        gm_we;
  logic [8:0]  gm_addr;
  logic [15:0] gm_wdata;
  logic        gm_gnt;
  logic        gm_rvalid;
  logic [15:0] gm_rdata;
  logic [8:0]  ram_addr;
  logic        ram_we;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;

  int n_vec;
  int n_bad;

  board_ram_arbiter dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear_start (clear_start),
    .clear_busy  (clear_busy),
    .vid_req     (vid_req),
    .vid_addr    (vid_addr),
    .vid_gnt     (vid_gnt),
    .vid_rvalid  (vid_rvalid),
    .vid_rdata   (vid_rdata),
    .gm_req      (gm_req),
    .gm_we       (gm_we),
    .gm_addr     (gm_addr),
    .gm_wdata    (gm_wdata),
    .gm_gnt      (gm_gnt),
    .gm_rvalid   (gm_rvalid),
    .gm_rdata    (gm_rdata),
    .ram_addr    (ram_addr),
    .ram_we      (ram_we),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: 512 words so out-of-range addresses hold recognisable data.
  logic [15:0] mem [512];
  logic        pre_en;
  logic [8:0]  pre_addr;
  logic [15:0] pre_data;

  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  typedef struct {
    logic        vreq;
    logic [8:0]  vaddr;
    logic        greq;
    logic        gwe;
    logic [8:0]  gaddr;
    logic [15:0] gwdata;
    logic        e_vgnt;
    logic        e_ggnt;
    logic        e_we;
    logic [8:0]  e_addr;
    logic [15:0] e_wdata;
    logic        e_vv;
    logic [15:0] e_vd;
    logic        e_gv;
    logic [15:0] e_gd;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string name);
    chk({name, " ctl"}, 64'({clear_busy, vid_gnt, gm_gnt, vid_rvalid, gm_rvalid, ram_we, ram_addr}), 64'd0);
    chk({name, " data"}, 64'({vid_rdata, gm_rdata, ram_wdata}), 64'd0);
  endtask

  task automatic preload(input logic [8:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    pre_addr = a;
    pre_data = d;
    pre_en   = 1'b1;
    @(posedge clk); #1;
    pre_en   = 1'b0;
  endtask

  // Watches a clear from the current cycle on. Each cycle with clear_busy
  // must write 0 to the next address with no grants. Optionally re-pulses
  // clear_start, or asserts reset when the write address hits abort_at.
  task automatic clear_watch(input bit hold, input int repulse_at, input int abort_at,
                             output int nwrites, output int rv_cyc, output logic [15:0] rv_data);
    bit done;
    nwrites = 0;
    rv_cyc  = -1;
    rv_data = '0;
    done    = 1'b0;
    for (int cyc = 0; cyc < 1000 && !done; cyc++) begin
      @(negedge clk);
      clear_start = (cyc == repulse_at);
      if (vid_rvalid && rv_cyc < 0) begin
        rv_cyc  = cyc;
        rv_data = vid_rdata;
      end
      if (clear_busy && ram_we && abort_at >= 0 && int'(ram_addr) == abort_at) begin
        reset_n = 1'b0;
        #1;
        check_reset("mid-clear reset");
        done = 1'b1;
      end else if (clear_busy) begin
        chk("clear we", 64'(ram_we), 64'd1);
        chk("clear addr/data", 64'({ram_addr, ram_wdata}), 64'({nwrites[8:0], 16'h0000}));
        if (hold) chk("clear no gnt", 64'({vid_gnt, gm_gnt}), 64'd0);
        nwrites++;
      end else if (nwrites > 0) begin
        done = 1'b1;
      end else begin
        chk("we before clear", 64'(ram_we), 64'd0);
      end
    end
    clear_start = 1'b0;
    if (!done) chk("clear timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int          nw;
    int          rc;
    logic [15:0] rd;

    n_vec = 0;
    n_bad = 0;
    reset_n = 1'b0;
    clear_start = 1'b0;
    vid_req = 1'b0; vid_addr = '0;
    gm_req = 1'b0; gm_we = 1'b0; gm_addr = '0; gm_wdata = '0;
    pre_en = 1'b0; pre_addr = '0; pre_data = '0;

    //          vq    va      gq    gw    ga       gd        vg    gg    we    ea       ewd       vv    vd        gv    gd
    vecs[0]  = '{1'b1, 9'd5,   1'b0, 1'b0, 9'd0,   16'h0000, 1'b1, 1'b0, 1'b0, 9'd5,   16'h0000, 1'b1, 16'h1234, 1'b0, 16'h0000};
    vecs[1]  = '{1'b0, 9'd0,   1'b1, 1'b1, 9'd10,  16'hBEEF, 1'b0, 1'b1, 1'b1, 9'd10,  16'hBEEF, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vecs[2]  = '{1'b0, 9'd0,   1'b1, 1'b0, 9'd10,  16'h0000, 1'b0, 1'b1, 1'b0, 9'd10,  16'h0000, 1'b0, 16'h0000, 1'b1, 16'hBEEF};
    vecs[3]  = '{1'b1, 9'd10,  1'b0, 1'b0, 9'd0,   16'h0000, 1'b1, 1'b0, 1'b0, 9'd10,  16'h0000, 1'b1, 16'hBEEF, 1'b0, 16'h0000};
    vecs[4]  = '{1'b0, 9'd0,   1'b1, 1'b1, 9'd450, 16'h5555, 1'b0, 1'b1, 1'b0, 9'd450, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vecs[5]  = '{1'b0, 9'd0,   1'b1, 1'b0, 9'd450, 16'h0000, 1'b0, 1'b1, 1'b0, 9'd450, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000};
    vecs[6]  = '{1'b1, 9'd450, 1'b0, 1'b0, 9'd0,   16'h0000, 1'b1, 1'b0, 1'b0, 9'd450, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0000};
    vecs[7]  = '{1'b1, 9'd20,  1'b1, 1'b0, 9'd10,  16'h0000, 1'b1, 1'b0, 1'b0, 9'd20,  16'h0000, 1'b1, 16'h00AB, 1'b0, 16'h0000};
    vecs[8]  = '{1'b0, 9'd0,   1'b0, 1'b0, 9'd0,   16'h0000, 1'b0, 1'b0, 1'b0, 9'd0,   16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vecs[9]  = '{1'b0, 9'd0,   1'b1, 1'b1, 9'd399, 16'h0F0F, 1'b0, 1'b1, 1'b1, 9'd399, 16'h0F0F, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vecs[10] = '{1'b0, 9'd0,   1'b1, 1'b0, 9'd399, 16'h0000, 1'b0, 1'b1, 1'b0, 9'd399, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0F0F};
    vecs[11] = '{1'b0, 9'd0,   1'b1, 1'b1, 9'd400, 16'h7777, 1'b0, 1'b1, 1'b0, 9'd400, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vecs[12] = '{1'b1, 9'd400, 1'b1, 1'b1, 9'd399, 16'h1111, 1'b1, 1'b0, 1'b0, 9'd400, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0000};

    // Reset state, then the power-up clear.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    clear_watch(1'b0, -1, -1, nw, rc, rd);
    chk("power-up clear writes", 64'(nw), 64'd400);

    preload(9'd5,   16'h1234);
    preload(9'd20,  16'h00AB);
    preload(9'd400, 16'hBBBB);
    preload(9'd450, 16'hDEAD);

    // Table: drive in T, check grant/RAM port in T, rvalid low in T+1,
    // result in T+2.
    for (int i = 0; i < NVEC; i++) begin
      @(posedge clk); #1;
      vid_req = vecs[i].vreq; vid_addr = vecs[i].vaddr;
      gm_req = vecs[i].greq; gm_we = vecs[i].gwe;
      gm_addr = vecs[i].gaddr; gm_wdata = vecs[i].gwdata;
      @(negedge clk);
      chk($sformatf("vec%0d vid_gnt", i), 64'(vid_gnt), 64'(vecs[i].e_vgnt));
      chk($sformatf("vec%0d gm_gnt", i), 64'(gm_gnt), 64'(vecs[i].e_ggnt));
      chk($sformatf("vec%0d ram_we", i), 64'(ram_we), 64'(vecs[i].e_we));
      if (vecs[i].e_vgnt || vecs[i].e_ggnt)
        chk($sformatf("vec%0d ram_addr", i), 64'(ram_addr), 64'(vecs[i].e_addr));
      if (vecs[i].e_we)
        chk($sformatf("vec%0d ram_wdata", i), 64'(ram_wdata), 64'(vecs[i].e_wdata));
      @(posedge clk); #1;
      vid_req = 1'b0; gm_req = 1'b0; gm_we = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d early rvalid", i), 64'({vid_rvalid, gm_rvalid}), 64'd0);
      @(negedge clk);
      chk($sformatf("vec%0d vid_rvalid", i), 64'(vid_rvalid), 64'(vecs[i].e_vv));
      chk($sformatf("vec%0d gm_rvalid", i), 64'(gm_rvalid), 64'(vecs[i].e_gv));
      if (vecs[i].e_vv) chk($sformatf("vec%0d vid_rdata", i), 64'(vid_rdata), 64'(vecs[i].e_vd));
      if (vecs[i].e_gv) chk($sformatf("vec%0d gm_rdata", i), 64'(gm_rdata), 64'(vecs[i].e_gd));
    end

    // Starvation: both held; video wins 8 cycles, game gets the 9th, repeat.
    @(posedge clk); #1;
    vid_req = 1'b1; vid_addr = 9'd5;
    gm_req = 1'b1; gm_we = 1'b0; gm_addr = 9'd10;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      chk($sformatf("starve c%0d vid_gnt", c), 64'(vid_gnt), 64'((c % 9) != 8));
      chk($sformatf("starve c%0d gm_gnt", c), 64'(gm_gnt), 64'((c % 9) == 8));
    end
    @(posedge clk); #1;
    vid_req = 1'b0; gm_req = 1'b0;
    repeat (3) @(posedge clk);

    // clear_start alongside a video grant: its data still returns; requests
    // held through the clear are never granted; a re-pulse does not extend it.
    #1;
    vid_req = 1'b1; vid_addr = 9'd5; clear_start = 1'b1;
    @(negedge clk);
    chk("clear_start cycle vid_gnt", 64'(vid_gnt), 64'd1);
    @(posedge clk); #1;
    clear_start = 1'b0;
    gm_req = 1'b1; gm_we = 1'b1; gm_addr = 9'd10; gm_wdata = 16'hFFFF;
    clear_watch(1'b1, 100, -1, nw, rc, rd);
    chk("cmd clear writes", 64'(nw), 64'd400);
    chk("pre-clear vid_rvalid cycle", 64'(rc), 64'd1);
    chk("pre-clear vid_rdata", 64'(rd), 64'h1234);
    @(posedge clk); #1;
    vid_req = 1'b0; gm_req = 1'b0; gm_we = 1'b0;
    repeat (3) @(posedge clk);

    // Reset in the middle of a clear, then the clear restarts from 0.
    #1;
    clear_start = 1'b1;
    @(posedge clk); #1;
    clear_start = 1'b0;
    clear_watch(1'b0, -1, 200, nw, rc, rd);
    chk("abort point writes", 64'(nw), 64'd200);
    repeat (2) @(posedge clk);
    @(posedge clk); #1;
    reset_n = 1'b1;
    clear_watch(1'b0, -1, -1, nw, rc, rd);
    chk("restarted clear writes", 64'(nw), 64'd400);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
